// File: rtl/apb_fifo_slave_if.sv
// APB2 bus bundle for the FIFO peripheral: the bridge side drives the request
// and the peripheral returns registered read data and a level interrupt.
interface apb_fifo_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        IRQ;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, IRQ
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, IRQ
    );
endinterface

// File: rtl/apb_fifo_slave.sv
// APB2 peripheral exposing a DEPTH x 32 FIFO through four word registers:
// DATA (push/pop), STATUS, CTRL (irq enable, flush, level) and CLR (sticky clear).
// Read data is captured at the end of setup; all side effects commit at the end
// of access, so PRDATA always reflects state before the current access commits.
module apb_fifo_slave #(
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  logic                HCLK,
    input  logic                HRESET,
    apb_fifo_slave_if.slave     bus
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]      LVL_MAX  = 8'(DEPTH);
    localparam logic [7:0]      LVL_RST  = 8'(THRESH);

    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_CLR = 2'd3;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          irq_en_q, irq_en_d;
    logic [7:0]    level_q, level_d;
    logic [31:0]   prdata_q, prdata_d;
    logic          irq_q, irq_d;

    logic          setup, access, empty, full, we;
    logic          ovf_set, unf_set, clr_wr;
    logic [1:0]    sel;
    logic [7:0]    wlvl;

    // Only PADDR[3:2] is decoded; the remaining address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{bus.PADDR[31:4], bus.PADDR[1:0]};

    assign bus.PRDATA = prdata_q;
    assign bus.IRQ    = irq_q;

    // Decode the APB phase and compute next FIFO/CSR state and captured read data.
    always_comb begin
        setup    = bus.PSEL & ~bus.PENABLE;
        access   = bus.PSEL &  bus.PENABLE;
        sel      = bus.PADDR[3:2];
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        wlvl     = bus.PWDATA[15:8];

        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        irq_en_d = irq_en_q;
        level_d  = level_q;
        prdata_d = prdata_q;
        we       = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        clr_wr   = access & bus.PWRITE & (sel == A_CLR);

        if (access && sel == A_DATA) begin
            if (bus.PWRITE) begin
                if (full) ovf_set = 1'b1;
                else begin
                    we      = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (empty) unf_set = 1'b1;
                else begin
                    rptr_d  = rptr_q + 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
        end

        if (access && bus.PWRITE && sel == A_CTRL) begin
            irq_en_d = bus.PWDATA[0];
            if (wlvl == 8'd0)        level_d = 8'd1;
            else if (wlvl > LVL_MAX) level_d = LVL_MAX;
            else                     level_d = wlvl;
            if (bus.PWDATA[1]) begin
                wptr_d  = '0;
                rptr_d  = '0;
                count_d = '0;
            end
        end

        // A set in the same cycle as a clear of that bit wins.
        ovf_d = ovf_set | (ovf_q & ~(clr_wr & bus.PWDATA[2]));
        unf_d = unf_set | (unf_q & ~(clr_wr & bus.PWDATA[3]));

        if (setup && !bus.PWRITE) begin
            case (sel)
                A_DATA:   prdata_d = empty ? 32'h0 : mem[rptr_q];
                A_STATUS: prdata_d = {16'h0, 8'(count_q), 4'h0, unf_q, ovf_q, full, empty};
                A_CTRL:   prdata_d = {16'h0, level_q, 7'h0, irq_en_q};
                default:  prdata_d = 32'h0;
            endcase
        end

        irq_d = irq_en_q & ((8'(count_q) >= level_q) | ovf_q | unf_q);
    end

    // State registers; reset aborts any in-flight access.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            level_q  <= LVL_RST;
            prdata_q <= 32'h0;
            irq_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_en_q <= irq_en_d;
            level_q  <= level_d;
            prdata_q <= prdata_d;
            irq_q    <= irq_d;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge HCLK) begin
        if (we) mem[wptr_q] <= bus.PWDATA;
    end
endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed bench for apb_fifo_slave: stimulus pushes expected read data and
// observation points into queues; a negedge monitor pops and compares.
module tb_apb_fifo_slave;
    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    apb_fifo_slave_if bus ();
    apb_fifo_slave #(.DEPTH(16), .THRESH(8)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

    typedef struct { string name; logic [31:0] exp; } rd_exp_t;
    typedef struct { string name; bit chk_pr; logic [31:0] pr; logic irq; } obs_exp_t;

    rd_exp_t  rd_q[$];
    obs_exp_t obs_q[$];
    logic     obs_stb = 1'b0;
    int       checks = 0;
    int       failures = 0;

    // Monitor: read data during every read access phase; observation points on strobe.
    always @(negedge HCLK) begin
        if (!HRESET && bus.PSEL && bus.PENABLE && !bus.PWRITE) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read got=%h exp=<none>", bus.PRDATA);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                if (bus.PRDATA !== e.exp) begin
                    failures++;
                    $display("FAIL %s got=%h exp=%h", e.name, bus.PRDATA, e.exp);
                end
            end
        end
        if (obs_stb && obs_q.size() != 0) begin
            obs_exp_t o;
            o = obs_q.pop_front();
            checks++;
            if (bus.IRQ !== o.irq) begin
                failures++;
                $display("FAIL %s_irq got=%b exp=%b", o.name, bus.IRQ, o.irq);
            end
            if (o.chk_pr) begin
                checks++;
                if (bus.PRDATA !== o.pr) begin
                    failures++;
                    $display("FAIL %s_prdata got=%h exp=%h", o.name, bus.PRDATA, o.pr);
                end
            end
        end
    end

    // Each transfer starts at posedge+1 and leaves the bus idle at posedge+1,
    // so consecutive calls produce back-to-back transfers.
    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = addr; bus.PWDATA = data;
        @(posedge HCLK); #1 bus.PENABLE = 1'b1;
        @(posedge HCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name; e.exp = exp;
        rd_q.push_back(e);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = addr; bus.PWDATA = 32'h0;
        @(posedge HCLK); #1 bus.PENABLE = 1'b1;
        @(posedge HCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic observe(input string name, input bit chk_pr, input logic [31:0] pr, input logic irq);
        obs_exp_t o;
        @(posedge HCLK); #1;
        o.name = name; o.chk_pr = chk_pr; o.pr = pr; o.irq = irq;
        obs_q.push_back(o);
        obs_stb = 1'b1;
        @(posedge HCLK); #1 obs_stb = 1'b0;
    endtask

    localparam logic [31:0] DATA = 32'h0, STATUS = 32'h4, CTRL = 32'h8, CLR = 32'hC;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 32'h0; bus.PWDATA = 32'h0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state
        observe("reset", 1'b1, 32'h0, 1'b0);
        apb_rd(STATUS, 32'h0000_0001, "reset_status");
        apb_rd(CTRL,   32'h0000_0800, "reset_ctrl");

        // Reset in the middle of a write access aborts it
        apb_wr(DATA, 32'h55);
        apb_rd(STATUS, 32'h0000_0100, "pre_rst_status");
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = DATA; bus.PWDATA = 32'h66;
        @(posedge HCLK); #1 bus.PENABLE = 1'b1;
        @(negedge HCLK); HRESET = 1'b1;
        @(posedge HCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(posedge HCLK); #1 HRESET = 1'b0;
        observe("midrst", 1'b1, 32'h0, 1'b0);
        apb_rd(STATUS, 32'h0000_0001, "midrst_status");

        // Fill / drain
        for (int i = 0; i < 16; i++) apb_wr(DATA, 32'h11 + i);
        apb_rd(STATUS, 32'h0000_1002, "full_status");
        for (int i = 0; i < 16; i++) apb_rd(DATA, 32'h11 + i, "drain");
        apb_rd(STATUS, 32'h0000_0001, "drained_status");

        // Overflow: 17th push dropped, sticky flag, CLR
        for (int i = 0; i < 16; i++) apb_wr(DATA, 32'h30 + i);
        apb_wr(DATA, 32'hDEAD);
        apb_rd(STATUS, 32'h0000_1006, "ovf_status");
        apb_wr(CLR, 32'h4);
        apb_rd(STATUS, 32'h0000_1002, "ovf_clr_status");
        for (int i = 0; i < 16; i++) apb_rd(DATA, 32'h30 + i, "ovf_drain");

        // Underflow
        apb_rd(DATA, 32'h0, "unf_data");
        apb_rd(STATUS, 32'h0000_0009, "unf_status");
        apb_wr(CLR, 32'h8);
        apb_rd(STATUS, 32'h0000_0001, "unf_clr_status");

        // IRQ at level 4
        apb_wr(CTRL, 32'h0000_0401);
        apb_rd(CTRL, 32'h0000_0401, "ctrl_rb");
        for (int i = 1; i <= 3; i++) apb_wr(DATA, i);
        observe("irq_3", 1'b0, 32'h0, 1'b0);
        apb_wr(DATA, 32'h4);
        observe("irq_4", 1'b0, 32'h0, 1'b1);
        apb_rd(DATA, 32'h1, "irq_pop");
        observe("irq_pop", 1'b0, 32'h0, 1'b0);

        // Flush (level 0 clamps to 1), then level above DEPTH clamps to DEPTH
        apb_wr(CTRL, 32'h0000_0002);
        apb_rd(STATUS, 32'h0000_0001, "flush_status");
        apb_rd(CTRL, 32'h0000_0100, "clamp_lo");
        apb_wr(CTRL, 32'h0000_FF00);
        apb_rd(CTRL, 32'h0000_1000, "clamp_hi");

        // Wrap: push 10, pop 10, push 12, read back in order
        for (int i = 0; i < 10; i++) apb_wr(DATA, 32'h100 + i);
        for (int i = 0; i < 10; i++) apb_rd(DATA, 32'h100 + i, "wrap_a");
        for (int i = 0; i < 12; i++) apb_wr(DATA, 32'h200 + i);
        apb_rd(STATUS, 32'h0000_0C00, "wrap_status");
        for (int i = 0; i < 12; i++) apb_rd(DATA, 32'h200 + i, "wrap_b");

        // Flush a non-empty FIFO; sticky flags survive a flush
        for (int i = 0; i < 3; i++) apb_wr(DATA, 32'h300 + i);
        apb_rd(DATA, 32'h300, "pre_flush_pop");
        apb_rd(DATA, 32'h301, "pre_flush_pop");
        apb_rd(DATA, 32'h302, "pre_flush_pop");
        apb_rd(DATA, 32'h0, "unf_again");
        for (int i = 0; i < 5; i++) apb_wr(DATA, 32'h400 + i);
        apb_wr(CTRL, 32'h0000_0002);
        apb_rd(STATUS, 32'h0000_0009, "flush_keeps_unf");
        apb_rd(DATA, 32'h0, "flushed_data");

        repeat (2) @(posedge HCLK);
        checks++;
        if (rd_q.size() != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations got=%0d exp=0", rd_q.size() + obs_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
